// File: rtl/time_of_day_counter_if.sv
// Signal bundle between the time-of-day counter and its environment:
// the 1 Hz seconds input, run/set controls and the six BCD display digits.
interface time_of_day_counter_if;
    logic       sec_clk;
    logic       run;
    logic       inc_min;
    logic       inc_hr;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic [3:0] hr_ones;
    logic [3:0] hr_tens;
    logic       tick;
    logic       day_wrap;

    modport master (
        output sec_clk, run, inc_min, inc_hr,
        input  sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
        input  tick, day_wrap
    );

    modport slave (
        input  sec_clk, run, inc_min, inc_hr,
        output sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens,
        output tick, day_wrap
    );
endinterface

// File: rtl/time_of_day_counter.sv
// BCD 24-hour HH:MM:SS counter. The 1 Hz sec_clk and the two set buttons are
// treated as asynchronous levels: each is synchronized into clk, then
// rising-edge detected. Manual set edges take priority over a coincident
// second and never carry into the next field.
module time_of_day_counter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    time_of_day_counter_if.slave  tod
);

    // bit 0 = sec_clk, bit 1 = inc_min, bit 2 = inc_hr
    logic [SYNC_STAGES-1:0] sync_sec;
    logic [SYNC_STAGES-1:0] sync_min;
    logic [SYNC_STAGES-1:0] sync_hr;
    logic [SYNC_STAGES-1:0] prime;
    logic [2:0]             synced;
    logic [2:0]             hist;
    logic [2:0]             armed;
    logic [2:0]             rise;

    // {tens, ones} per field
    logic [7:0] sec_q, min_q, hr_q;
    logic [7:0] sec_d, min_d, hr_d;
    logic       tick_q, tick_d;
    logic       wrap_q, wrap_d;

    logic sec_ev, sec_max, min_max, hr_max, min_step, hr_step;

    function automatic logic [7:0] inc60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) return 8'h00;
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc24(input logic [7:0] v);
        if (v == 8'h23) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign synced = {sync_hr[SYNC_STAGES-1], sync_min[SYNC_STAGES-1], sync_sec[SYNC_STAGES-1]};
    assign rise   = armed & synced & ~hist;

    // Synchronizers, history and arming. Reset-cleared stages read 0 without
    // reflecting the pin, so arming waits until 'prime' shows the chain has
    // flushed; an input held high through reset therefore cannot fire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_sec <= '0;
            sync_min <= '0;
            sync_hr  <= '0;
            prime    <= '0;
            hist     <= '0;
            armed    <= '0;
        end else begin
            sync_sec <= {sync_sec[SYNC_STAGES-2:0], tod.sec_clk};
            sync_min <= {sync_min[SYNC_STAGES-2:0], tod.inc_min};
            sync_hr  <= {sync_hr[SYNC_STAGES-2:0],  tod.inc_hr};
            prime    <= {prime[SYNC_STAGES-2:0], 1'b1};
            hist     <= synced;
            armed    <= armed | ({3{prime[SYNC_STAGES-1]}} & ~synced);
        end
    end

    // Next time: a second ripples through the carry chain, manual edges bump
    // only their own field, and any manual edge suppresses the second.
    always_comb begin
        sec_d    = sec_q;
        min_d    = min_q;
        hr_d     = hr_q;
        sec_ev   = rise[0] & tod.run & ~rise[1] & ~rise[2];
        sec_max  = (sec_q == 8'h59);
        min_max  = (min_q == 8'h59);
        hr_max   = (hr_q == 8'h23);
        min_step = (sec_ev & sec_max) | rise[1];
        hr_step  = (sec_ev & sec_max & min_max) | rise[2];
        tick_d   = sec_ev;
        wrap_d   = sec_ev & sec_max & min_max & hr_max;
        if (sec_ev)   sec_d = inc60(sec_q);
        if (min_step) min_d = inc60(min_q);
        if (hr_step)  hr_d  = inc24(hr_q);
    end

    // Time and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign tod.sec_ones = sec_q[3:0];
    assign tod.sec_tens = sec_q[7:4];
    assign tod.min_ones = min_q[3:0];
    assign tod.min_tens = min_q[7:4];
    assign tod.hr_ones  = hr_q[3:0];
    assign tod.hr_tens  = hr_q[7:4];
    assign tod.tick     = tick_q;
    assign tod.day_wrap = wrap_q;

endmodule
